button_sequencer: RTL and testbench
===================================

BUTTON_SEQUENCER -- requirements
Module: button_sequencer

Interface
REQ-001 The parameter DEBOUNCE_CYCLES SHALL default to 500000 and set the consecutive stable samples needed to accept a level change.
REQ-002 The parameter REPEAT_DELAY SHALL default to 25000000 and set the cycles between the first inc/dec pulse and the first repeat pulse.
REQ-003 The parameter REPEAT_PERIOD SHALL default to 5000000 and set the cycles between subsequent repeat pulses.
REQ-004 The port CLK SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-005 The port RESET SHALL be an input, 1 bit wide, asynchronous and active-high.
REQ-006 The port btnRaw SHALL be an input, 5 bits wide, carrying raw asynchronous buttons: [0] left, [1] right, [2] up(inc), [3] down(dec), [4] execute.
REQ-007 The ports moveLeftDec, moveRightDec, inc, dec and execute SHALL be outputs, 1 bit each, carrying single-cycle command pulses.
REQ-008 The port locked SHALL be a 1-bit output, high once execute has been issued.

Function
REQ-009 Each btnRaw bit SHALL pass a 2-flop synchronizer, then a debouncer that flips its stable level only after DEBOUNCE_CYCLES consecutive synchronized samples differing from it.
REQ-010 A press event SHALL be a stable-level 0->1 transition; a release SHALL be a 1->0 transition.
REQ-011 At most one command output SHALL be high in any cycle, each for exactly one cycle per issue.
REQ-012 The FSM SHALL have states IDLE, HOLD, REPEAT, WAIT_REL.
REQ-013 In IDLE, on press events, the sequencer SHALL select one button by priority left > right > inc > dec > execute, pulse its command the next cycle, and latch its id.
REQ-014 After an inc/dec issue the FSM SHALL go to HOLD; after any other issue it SHALL go to WAIT_REL.
REQ-015 HOLD SHALL count REPEAT_DELAY cycles; at terminal count it SHALL pulse the latched command and go to REPEAT.
REQ-016 REPEAT SHALL pulse the latched command every REPEAT_PERIOD cycles.
REQ-017 In HOLD, REPEAT or WAIT_REL, release of the latched button SHALL return the FSM to IDLE the next cycle with no further pulse, including when release coincides with a terminal count.
REQ-018 Presses of other buttons outside IDLE SHALL be discarded, not queued; unselected simultaneous presses in IDLE SHALL likewise be discarded.
REQ-019 A clean press SHALL produce its first pulse exactly DEBOUNCE_CYCLES+3 cycles after the first CLK edge sampling btnRaw high.
REQ-020 Issuing execute SHALL set locked the same cycle as the execute pulse.
REQ-021 While locked, the sequencer SHALL suppress all command pulses, keeping the FSM sequencing internally.
REQ-022 Repeat counters SHALL be wide enough for the parameters, never wrap, and reload on each pulse.

Reset
REQ-023 RESET high SHALL asynchronously clear all command outputs, locked, the synchronizers, the debounced levels, the counters and the latched id, and force IDLE.
REQ-024 RESET asserted mid-hold SHALL abort repeating; a button held through reset release SHALL issue nothing until a fresh press event.

Configuration
REQ-025 With BTN_AUTOREPEAT_EN defined, inc/dec SHALL follow REQ-014..016.
REQ-026 Without BTN_AUTOREPEAT_EN, every issue SHALL go to WAIT_REL, HOLD and REPEAT SHALL be unreachable, and the repeat counters SHALL be absent.

Structure
REQ-027 The package button_seq_pkg SHALL hold the FSM state encoding, the button index constants (BTN_LEFT..BTN_EXEC) and the priority order.
REQ-028 Synchronizer plus debouncer SHALL be one sub-module, btn_debounce, instantiated five times.

Verification
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8 with BTN_AUTOREPEAT_EN defined unless stated.
REQ-029 Clean left press held 50 cycles -> one moveLeftDec pulse at cycle 7, no others.
REQ-030 Up bounces 3 cycles high, 1 low, then stays high -> no pulse during the bounce, then one inc 7 cycles after the stable rise.
REQ-031 Down held 60 cycles -> dec pulses at 7, 27, 35, 43, 51, 59; release -> stop; rebuild without the macro -> single dec at 7.
REQ-032 Left and up rise in the same cycle -> only moveLeftDec; up press during WAIT_REL -> no inc.
REQ-033 Execute press -> execute pulse and locked=1; later up press -> no inc, locked stays 1.
REQ-034 RESET pulsed during REPEAT with down held -> outputs 0 immediately, no dec until down released and re-pressed.

Source files
------------

// File: rtl/button_seq_pkg.sv
// button_seq_pkg: state encoding, button indices and selection priority shared by
// button_sequencer and its debouncers.
package button_seq_pkg;
   localparam int NUM_BTN = 5;
   typedef logic [2:0] btn_id_t;
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} state_t;
   localparam btn_id_t BTN_LEFT  = 3'd0;
   localparam btn_id_t BTN_RIGHT = 3'd1;
   localparam btn_id_t BTN_INC   = 3'd2;
   localparam btn_id_t BTN_DEC   = 3'd3;
   localparam btn_id_t BTN_EXEC  = 3'd4;
   localparam btn_id_t BTN_PRIO [NUM_BTN] = '{BTN_LEFT, BTN_RIGHT, BTN_INC, BTN_DEC, BTN_EXEC};
   // Highest-priority button among the flagged events; only meaningful when ev != 0.
   function automatic btn_id_t pick_btn(input logic [NUM_BTN-1:0] ev);
      pick_btn = BTN_PRIO[NUM_BTN-1];
      for (int i = NUM_BTN - 1; i >= 0; i--)
         if (ev[BTN_PRIO[i]]) pick_btn = BTN_PRIO[i];
   endfunction
endpackage

// File: rtl/button_sequencer_btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus counting debouncer for one raw button,
// emitting one-cycle press/release pulses from the accepted level.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press,
   output logic rel
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   logic [1:0]       sync_q, sync_d, vld_q, vld_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d, last_q, last_d, armed_q, armed_d;
   logic             press_q, press_d, rel_q, rel_d, diff, flip;
   // A button still held when reset drops is never armed, so it cannot issue until it
   // has been seen released once the synchronizer holds real samples.
   always_comb begin
      sync_d   = {sync_q[0], raw};
      vld_d    = {vld_q[0], 1'b1};
      armed_d  = armed_q | (vld_q[1] & ~sync_q[1]);
      diff     = sync_q[1] ^ stable_q;
      flip     = diff && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
      cnt_d    = (diff && !flip) ? cnt_q + CNT_W'(1) : '0;
      stable_d = stable_q ^ flip;
      last_d   = stable_q;
      press_d  = stable_q & ~last_q & armed_q;
      rel_d    = ~stable_q & last_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync_q   <= '0;
         vld_q    <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         last_q   <= 1'b0;
         armed_q  <= 1'b0;
         press_q  <= 1'b0;
         rel_q    <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         vld_q    <= vld_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         last_q   <= last_d;
         armed_q  <= armed_d;
         press_q  <= press_d;
         rel_q    <= rel_d;
      end
   assign press = press_q;
   assign rel   = rel_q;
endmodule

// File: rtl/button_sequencer.sv
// button_sequencer: five debounced buttons -> prioritized single-cycle command pulses with
// execute lockout. Define BTN_AUTOREPEAT_EN to auto-repeat inc/dec while held.
module button_sequencer
   import button_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [4:0] btnRaw,
   output logic       moveLeftDec,
   output logic       moveRightDec,
   output logic       inc,
   output logic       dec,
   output logic       execute,
   output logic       locked
);
   logic [NUM_BTN-1:0] press, rel, cmd_q, cmd_d;
   state_t             state_q, state_d;
   btn_id_t            id_q, id_d, sel;
   logic               locked_q, locked_d, issue, released;
   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_err
      $error("button_sequencer: timing parameters must be at least 1");
   end
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk  (CLK),
         .rst  (RESET),
         .raw  (btnRaw[i]),
         .press(press[i]),
         .rel  (rel[i])
      );
   end
`ifdef BTN_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);
   logic [RPT_W-1:0] rpt_q, rpt_d;
`endif
   // Release of the latched button wins over a coincident terminal count.
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      issue    = 1'b0;
      sel      = pick_btn(press);
      released = rel[id_q];
`ifdef BTN_AUTOREPEAT_EN
      rpt_d    = rpt_q;
`endif
      case (state_q)
         IDLE: if (|press) begin
            issue = 1'b1;
            id_d  = sel;
`ifdef BTN_AUTOREPEAT_EN
            state_d = (sel == BTN_INC || sel == BTN_DEC) ? HOLD : WAIT_REL;
            rpt_d   = RPT_W'(REPEAT_DELAY - 1);
`else
            state_d = WAIT_REL;
`endif
         end
`ifdef BTN_AUTOREPEAT_EN
         HOLD, REPEAT: if (released) state_d = IDLE;
         else if (rpt_q == '0) begin
            issue   = 1'b1;
            state_d = REPEAT;
            rpt_d   = RPT_W'(REPEAT_PERIOD - 1);
         end else rpt_d = rpt_q - RPT_W'(1);
`endif
         WAIT_REL: if (released) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      cmd_d    = (issue && !locked_q) ? (NUM_BTN'(1) << id_d) : '0;
      locked_d = locked_q | (issue && id_d == BTN_EXEC);
   end
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         state_q  <= IDLE;
         id_q     <= BTN_LEFT;
         cmd_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         cmd_q    <= cmd_d;
         locked_q <= locked_d;
      end
`ifdef BTN_AUTOREPEAT_EN
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) rpt_q <= '0;
      else rpt_q <= rpt_d;
`endif
   assign {execute, dec, inc, moveRightDec, moveLeftDec} = cmd_q;
   assign locked = locked_q;
endmodule

// File: tb/tb_button_sequencer.sv
// tb_button_sequencer: scenario table, hand-written corner sequences and random stimulus
// against an event-level reference model of button_sequencer.
module tb_button_sequencer;
   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 8;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   logic       CLK, RESET;
   logic [4:0] btnRaw, outs;
   logic       moveLeftDec, moveRightDec, inc, dec, execute, locked;
   int         checks = 0, failures = 0, now = 0;
   button_sequencer #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
      .CLK(CLK), .RESET(RESET), .btnRaw(btnRaw),
      .moveLeftDec(moveLeftDec), .moveRightDec(moveRightDec), .inc(inc), .dec(dec),
      .execute(execute), .locked(locked)
   );
   assign outs = {execute, dec, inc, moveRightDec, moveLeftDec};
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   // reference model: raw sample history, accepted levels, held button and next repeat time
   logic [4:0] raw_hist[$];
   logic [4:0] lvl_hist[$];
   int         first_low[5];
   int         held, fire, e;
   bit         m_locked;
   logic [4:0] m_pulse;
   int         pc[$];
   int         pp[$];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask
   function automatic logic [4:0] lvl_at(input int k);
      return (k < 0) ? 5'b0 : lvl_hist[k];
   endfunction
   task automatic model_reset();
      raw_hist.delete();
      lvl_hist.delete();
      for (int b = 0; b < 5; b++) first_low[b] = -1;
      held = -1;
      fire = -1;
      e = 0;
      m_locked = 1'b0;
      m_pulse = '0;
   endtask
   task automatic model_step(input logic [4:0] raw);
      logic [4:0] lvl, prs, rls, armed;
      int id;
      raw_hist.push_back(raw);
      lvl = lvl_at(e - 1);
      for (int b = 0; b < 5; b++) begin
         bit flip;
         if (!raw[b] && first_low[b] < 0) first_low[b] = e;
         flip = (e - 1 - D) >= 0;
         if (flip)
            for (int j = 0; j < D; j++)
               if (raw_hist[e - 2 - j][b] == lvl[b]) flip = 1'b0;
         if (flip) lvl[b] = ~lvl[b];
         armed[b] = first_low[b] >= 0 && first_low[b] <= e - 4;
      end
      lvl_hist.push_back(lvl);
      prs = lvl_at(e - 2) & ~lvl_at(e - 3) & armed;
      rls = ~lvl_at(e - 2) & lvl_at(e - 3);
      m_pulse = '0;
      if (held < 0) begin
         if (prs != 0) begin
            id = 0;
            for (int b = 4; b >= 0; b--) if (prs[b]) id = b;
            held = id;
            if (!m_locked) m_pulse[id] = 1'b1;
            if (id == 4) m_locked = 1'b1;
            fire = (AR && (id == 2 || id == 3)) ? e + RD : -1;
         end
      end else if (rls[held]) held = -1;
      else if (e == fire) begin
         if (!m_locked) m_pulse[held] = 1'b1;
         fire = e + RP;
      end
      e++;
   endtask
   task automatic tick();
      int cur;
      @(posedge CLK);
      cur = now;
      now++;
      if (RESET) model_reset();
      else model_step(btnRaw);
      @(negedge CLK);
      chk($sformatf("model@%0d", cur), {locked, outs}, {m_locked, m_pulse});
      for (int b = 0; b < 5; b++)
         if (outs[b]) begin
            pc.push_back(cur);
            pp.push_back(b);
         end
   endtask
   task automatic do_reset();
      RESET = 1'b1;
      btnRaw = '0;
      model_reset();
      tick();
      tick();
      RESET = 1'b0;
      repeat (4) tick();
   endtask
   function automatic int cnt_port(input int p);
      int n = 0;
      foreach (pp[k]) if (pp[k] == p) n++;
      return n;
   endfunction
   function automatic int first_cyc(input int p);
      foreach (pp[k]) if (pp[k] == p) return pc[k];
      return -1;
   endfunction
   function automatic int last_cyc(input int p);
      int c = -1;
      foreach (pp[k]) if (pp[k] == p) c = pc[k];
      return c;
   endfunction
   task automatic clr();
      pc.delete();
      pp.delete();
      now = 0;
   endtask
   typedef struct {
      logic [4:0] btn;
      int         hold;
      int         n;
      int         first;
      int         last;
      int         port;
   } rec_t;
   rec_t tbl[9];
   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      tbl[0] = '{5'b00001, 50, 1, 7, 7, 0};
      tbl[1] = '{5'b00010, 20, 1, 7, 7, 1};
      tbl[2] = '{5'b00100, 40, AR ? 4 : 1, 7, AR ? 43 : 7, 2};
      tbl[3] = '{5'b01000, 60, AR ? 6 : 1, 7, AR ? 59 : 7, 3};
      tbl[4] = '{5'b10000, 10, 1, 7, 7, 4};
      tbl[5] = '{5'b00101, 30, 1, 7, 7, 0};
      tbl[6] = '{5'b01000, 3, 0, -1, -1, 3};
      tbl[7] = '{5'b00100, 20, 1, 7, 7, 2};
      tbl[8] = '{5'b00100, 28, AR ? 2 : 1, 7, AR ? 27 : 7, 2};
      RESET = 1'b1;
      btnRaw = '0;
      model_reset();
      #3;
      chk("reset_outs", outs, 0);
      chk("reset_locked", locked, 0);
      @(negedge CLK);
      for (int r = 0; r < 9; r++) begin
         do_reset();
         clr();
         btnRaw = tbl[r].btn;
         repeat (tbl[r].hold) tick();
         btnRaw = '0;
         repeat (20) tick();
         chk($sformatf("rec%0d_count", r), pc.size(), tbl[r].n);
         if (tbl[r].n > 0) begin
            chk($sformatf("rec%0d_first", r), first_cyc(tbl[r].port), tbl[r].first);
            chk($sformatf("rec%0d_last", r), last_cyc(tbl[r].port), tbl[r].last);
            chk($sformatf("rec%0d_port", r), pp[0], tbl[r].port);
         end
      end
      // bouncing up button: stable rise at cycle 4, inc 7 cycles later
      do_reset();
      clr();
      btnRaw = 5'b00100;
      repeat (3) tick();
      btnRaw = '0;
      tick();
      btnRaw = 5'b00100;
      repeat (12) tick();
      btnRaw = '0;
      repeat (12) tick();
      chk("bounce_first", first_cyc(2), 11);
      chk("bounce_count", pc.size(), 1);
      // up pressed while left is latched is discarded, then a fresh up works
      do_reset();
      clr();
      btnRaw = 5'b00001;
      repeat (10) tick();
      btnRaw = 5'b00101;
      repeat (20) tick();
      btnRaw = 5'b00001;
      repeat (10) tick();
      btnRaw = '0;
      repeat (15) tick();
      chk("waitrel_left", cnt_port(0), 1);
      chk("waitrel_no_inc", cnt_port(2), 0);
      clr();
      btnRaw = 5'b00100;
      repeat (10) tick();
      btnRaw = '0;
      repeat (12) tick();
      chk("fresh_inc_first", first_cyc(2), 7);
      chk("fresh_inc_count", cnt_port(2), 1);
      // execute locks out later commands
      do_reset();
      clr();
      btnRaw = 5'b10000;
      repeat (10) tick();
      btnRaw = '0;
      repeat (10) tick();
      btnRaw = 5'b00100;
      repeat (40) tick();
      btnRaw = '0;
      repeat (10) tick();
      chk("lock_exec_count", cnt_port(4), 1);
      chk("lock_exec_first", first_cyc(4), 7);
      chk("lock_no_inc", cnt_port(2), 0);
      chk("lock_sticky", locked, 1);
      // reset at the first repeat edge with down held
      do_reset();
      clr();
      btnRaw = 5'b01000;
      repeat (27) tick();
      @(posedge CLK);
      model_step(btnRaw);
      now++;
      #1;
      chk("pre_reset_dec", dec, m_pulse[3]);
      RESET = 1'b1;
      #1;
      model_reset();
      chk("async_reset_outs", {locked, outs}, 0);
      @(negedge CLK);
      tick();
      RESET = 1'b0;
      clr();
      repeat (40) tick();
      chk("held_through_reset", pc.size(), 0);
      btnRaw = '0;
      repeat (10) tick();
      clr();
      btnRaw = 5'b01000;
      repeat (12) tick();
      chk("repress_dec_first", first_cyc(3), 7);
      btnRaw = '0;
      repeat (10) tick();
      // random stimulus against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 5; b++)
            if ($urandom_range(b == 4 ? 299 : 11, 0) == 0) btnRaw[b] = ~btnRaw[b];
         if ($urandom_range(799, 0) == 0) do_reset();
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
